// File: rtl/wb_port_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter: FSM encodings and the x0 address.
package wb_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PENDING = 2'd1,
    ST_FORCE   = 2'd2
  } wb_arb_state_e;

  localparam int unsigned X0_ADDR = 0;

endpackage

// File: rtl/wb_port_arbiter.sv
// Arbitrates the register-file write port between pipeline writeback (priority) and a long-latency unit,
// buffering one blocked long-latency result and forcing a one-cycle pipeline stall after MAX_WAIT blocked cycles.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pipe_we,
  input  logic [ADDR_W-1:0] pipe_addr,
  input  logic [DATA_W-1:0] pipe_data,
  input  logic              lu_valid,
  input  logic [ADDR_W-1:0] lu_addr,
  input  logic [DATA_W-1:0] lu_data,
  output logic              lu_ready,
  output logic              pipe_stall,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_data
);

  localparam int CNT_W = $clog2(MAX_WAIT) + 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MAX_WAIT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [ADDR_W-1:0] ADDR_X0  = ADDR_W'(X0_ADDR);

  wb_arb_state_e     state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              buf_vld_q, buf_vld_d;
  logic [ADDR_W-1:0] buf_addr_q;
  logic [DATA_W-1:0] buf_data_q;
  logic              capture;
  logic              pipe_nz, lu_nz, pipe_hit;

  assign pipe_nz  = (pipe_addr != ADDR_X0);
  assign lu_nz    = (lu_addr != ADDR_X0);
  assign pipe_hit = (pipe_addr == buf_addr_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_EMPTY;
      cnt_q     <= '0;
      buf_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      buf_vld_q <= buf_vld_d;
    end
  end

  // Payload only matters while buf_vld_q is set, so it carries no reset.
  always_ff @(posedge clk) begin
    if (capture) begin
      buf_addr_q <= lu_addr;
      buf_data_q <= lu_data;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    buf_vld_d = buf_vld_q;
    capture   = 1'b0;
    unique case (state_q)
      ST_EMPTY: begin
        // A blocked result to x0 is accepted and simply dropped.
        if (pipe_we && lu_valid && lu_nz) begin
          capture   = 1'b1;
          buf_vld_d = 1'b1;
          cnt_d     = '0;
          state_d   = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (!pipe_we || pipe_hit) begin
          buf_vld_d = 1'b0;
          state_d   = ST_EMPTY;
        end else begin
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_d = ST_FORCE;
        end
      end
      ST_FORCE: begin
        buf_vld_d = 1'b0;
        state_d   = ST_EMPTY;
      end
      default: begin
        buf_vld_d = 1'b0;
        state_d   = ST_EMPTY;
      end
    endcase
  end

  always_comb begin
    lu_ready   = 1'b0;
    pipe_stall = 1'b0;
    rf_we      = 1'b0;
    rf_addr    = '0;
    rf_data    = '0;
    if (reset) begin
      unique case (state_q)
        ST_EMPTY: begin
          lu_ready = 1'b1;
          if (pipe_we) begin
            rf_we   = pipe_nz;
            rf_addr = pipe_addr;
            rf_data = pipe_data;
          end else if (lu_valid) begin
            rf_we   = lu_nz;
            rf_addr = lu_addr;
            rf_data = lu_data;
          end
        end
        ST_PENDING: begin
          // Same-address pipeline write is younger and squashes the buffer.
          if (pipe_we) begin
            rf_we   = pipe_nz;
            rf_addr = pipe_addr;
            rf_data = pipe_data;
          end else begin
            rf_we   = buf_vld_q;
            rf_addr = buf_addr_q;
            rf_data = buf_data_q;
          end
        end
        ST_FORCE: begin
          pipe_stall = 1'b1;
          rf_we      = buf_vld_q;
          rf_addr    = buf_addr_q;
          rf_data    = buf_data_q;
        end
        default: ;
      endcase
    end
  end

endmodule
